// File: rtl/uart_rx_hs_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_hs_if
//  Description : Port bundle of the flow-controlled UART receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_hs_if #(
    parameter int DEPTH = 4
);
    logic                     rx_serial;
    logic                     rx_ready;
    logic [7:0]               rx_byte;
    logic                     rx_valid;
    logic                     cts;
    logic                     rx_active;
    logic                     frame_error;
    logic                     overrun;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        input  rx_serial,
        input  rx_ready,
        output rx_byte,
        output rx_valid,
        output cts,
        output rx_active,
        output frame_error,
        output overrun,
        output fifo_count
    );

    modport slave (
        output rx_serial,
        output rx_ready,
        input  rx_byte,
        input  rx_valid,
        input  cts,
        input  rx_active,
        input  frame_error,
        input  overrun,
        input  fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_hs.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_hs
//  Description : 8N1 UART receiver with show-ahead byte FIFO and registered CTS.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_hs #(
    parameter int FREQUENCY = 10000000,
    parameter int BAUD_RATE = 9600,
    parameter int DEPTH     = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_hs_if.master  bus
);
    localparam int       c_CLKS_PER_BIT = FREQUENCY / (16 * BAUD_RATE);
    localparam logic [7:0] c_HALF       = 8'((c_CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] c_LAST       = 8'(c_CLKS_PER_BIT - 1);
    localparam int       c_AW           = $clog2(DEPTH);
    localparam int       c_CW           = c_AW + 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic            r_sync1, r_sync2;
    logic [2:0]      r_state, w_state_next;
    logic [7:0]      r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_cts, r_frame_error, r_overrun;
    logic            w_rxs, w_active, w_stop_sample, w_byte_ok, w_frame_err;
    logic            w_valid, w_pop, w_full, w_push, w_overrun;

    // Flops start high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx_serial;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rxs = r_sync2;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (!w_rxs) w_state_next = ST_START;
            ST_START:     if (r_clk_cnt == c_HALF) w_state_next = w_rxs ? ST_IDLE : ST_DATA;
            ST_DATA:      if (r_clk_cnt == c_LAST && r_bit_idx == 3'd7) w_state_next = ST_STOP;
            ST_STOP:      if (r_clk_cnt == c_LAST) w_state_next = w_rxs ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (w_rxs) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_active      = (r_state != ST_IDLE);
        w_stop_sample = (r_state == ST_STOP) && (r_clk_cnt == c_LAST);
        w_byte_ok     = w_stop_sample && w_rxs;
        w_frame_err   = w_stop_sample && !w_rxs;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                ST_START: r_clk_cnt <= (r_clk_cnt == c_HALF) ? 8'd0 : r_clk_cnt + 8'd1;
                ST_DATA: begin
                    if (r_clk_cnt == c_LAST) begin
                        r_clk_cnt            <= 8'd0;
                        r_shift[r_bit_idx]   <= w_rxs;
                        r_bit_idx            <= r_bit_idx + 3'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                ST_STOP:  r_clk_cnt <= (r_clk_cnt == c_LAST) ? 8'd0 : r_clk_cnt + 8'd1;
                default: begin
                    r_clk_cnt <= 8'd0;
                    r_bit_idx <= 3'd0;
                end
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && bus.rx_ready;
    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_push    = w_byte_ok && (!w_full || w_pop);
    assign w_overrun = w_byte_ok && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_cts         <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - c_CW'(1);
            // One slot stays in reserve for a frame already on the wire.
            r_cts         <= (r_count < c_CW'(DEPTH - 1));
            r_frame_error <= w_frame_err;
            r_overrun     <= w_overrun;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift;
    end

    assign bus.rx_byte     = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.rx_valid    = w_valid;
    assign bus.cts         = r_cts;
    assign bus.rx_active   = w_active;
    assign bus.frame_error = r_frame_error;
    assign bus.overrun     = r_overrun;
    assign bus.fifo_count  = r_count;
endmodule
`default_nettype wire

// File: doc/uart_rx_hs.md
Name: uart_rx_hs

Overview:
UART receive stage with hardware flow control. It is the far-end consumer of the serial stream produced by the team's handshaked UART transmitter. It deserialises 8N1 frames using the same bit-period formula as the transmitter and buffers received bytes in a small FIFO. It drives cts to the transmitter so that a new frame is only started while buffer space remains.

Parameters:
FREQUENCY, 10000000, system clock frequency in Hz
BAUD_RATE, 9600, baud setting; bit period CLKS_PER_BIT = FREQUENCY/(16*BAUD_RATE) clocks, identical to the transmitter (default 65)
DEPTH, 4, receive FIFO depth in bytes; power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
rx_serial  input  1  asynchronous serial line, idle high
rx_ready  input  1  consumer accepts head byte when high
rx_byte  output  8  FIFO head byte, valid while rx_valid
rx_valid  output  1  FIFO non-empty
cts  output  1  clear-to-send to the transmitter
rx_active  output  1  frame reception in progress (any state other than IDLE)
frame_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped, FIFO full
fifo_count  output  clog2(DEPTH)+1  bytes held

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset takes priority, including mid-frame.
- Reset values: state IDLE, FIFO empty, rx_byte=0, rx_valid=0, cts=0, rx_active=0, frame_error=0, overrun=0, fifo_count=0. Synchroniser flops reset to 1.
- cts is registered. cts = (fifo_count < DEPTH-1) from the previous cycle. It is therefore 1 on the first clock after reset release. The reserved slot absorbs a frame already in flight when the FIFO fills.
- rx_serial passes through a 2-flop synchroniser; rxs denotes the synchronised value. All sampling below uses rxs.
- HALF = (CLKS_PER_BIT-1)/2, integer division. Clock counter is 8 bits wide; CLKS_PER_BIT must be <= 256.
- IDLE: counter=0, bit index=0. rxs==0 -> START.
- START: counter increments each cycle. At counter==HALF:
  - rxs==0 -> counter=0, go to DATA.
  - rxs==1 -> glitch; return to IDLE with no flags.
- DATA: counter counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1 (mid-bit):
  - shift rxs into bit[index], LSB first, and set counter=0.
  - After index 7 -> STOP; otherwise index+1.
- STOP: at counter==CLKS_PER_BIT-1, sample rxs.
  - rxs==1: push the byte and go to IDLE. If the FIFO is full and no pop occurs that cycle, the byte is dropped and overrun pulses instead.
  - rxs==0: frame_error pulses, nothing is pushed, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs==1, then IDLE. This prevents a break condition being taken as a start bit.
- FIFO is show-ahead:
  - rx_byte = head; rx_valid = (fifo_count != 0).
  - Pop when rx_valid && rx_ready.
  - A push becomes visible on rx_valid/rx_byte the cycle after the stop-bit sample.
  - Simultaneous push and pop is allowed at any count, including full. fifo_count is unchanged and the order is preserved.
  - Pointers wrap modulo DEPTH.
- rx_ready with the FIFO empty: no effect.
- Latency: the byte is available ceil(9.5 bit periods) + 3 clocks after the rx_serial falling edge, nominally.

Test Plan:
Test configuration: FREQUENCY=1600000, BAUD_RATE=10000, giving CLKS_PER_BIT=10 and HALF=4.
1. Release reset with rx_serial=1 -> cts=1 on the next cycle, rx_valid=0, fifo_count=0. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with rx_ready=1 -> rx_valid high exactly 1 cycle, rx_byte=0xA5, no flags.
2. Hold rx_serial low for 3 clocks, then high -> START aborts at HALF, back to IDLE, rx_active low again, no push, no flags.
3. Frame 0x3C with stop bit driven 0, held low 30 clocks, then high; then frame 0x11 -> frame_error pulses once, state held in WAIT_IDLE while low, then 0x11 received correctly.
4. DEPTH=4, rx_ready=0; send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back -> cts falls after 0x03 is stored; 0x04 stored with fifo_count=4; 0x05 dropped with an overrun pulse. Then rx_ready=1 -> bytes pop out as 0x01..0x04 on consecutive cycles, cts returns to 1.
5. Full FIFO; assert rx_ready for exactly the cycle the stop bit of 0x66 is sampled -> no overrun, fifo_count stays 4, and 0x66 emerges last.
6. Assert reset for 1 clock during data bit 3 of a frame, with 2 bytes buffered -> all outputs return to reset values; the next complete frame 0xC3 is received correctly.
